// File: rtl/pmipsl_fetch_unit.sv
// Instruction-fetch front end: PC sequencer, req/ack imem port, DEPTH-entry instruction buffer.
// Latency: first request 1 cycle after reset release; with 0-wait memory an instruction reaches decode 2 cycles after release.
// Backpressure: decode stalls via idready=0; a full buffer parks the sequencer in HOLD with no request outstanding.
//
// Ports:
//   clock, reset               rising-edge clock, asynchronous active-high reset
//   imemaddr/imemreq           fetch address and request, held stable until imemack
//   imemrdata/imemack          returned instruction and completion strobe
//   redirect/redirectaddr      taken branch/jump: flush buffer and reload PC
//   idvalid/idinstr/idpcplus   head of buffer towards decode (idpcplus = PC+INC of that instruction)
//   idready                    decode consumes the head this cycle
//   bufcount                   occupied buffer entries
module pmipsl_fetch_unit #(
  parameter int              AW       = 16,
  parameter int              IW       = 17,
  parameter int              INC      = 2,
  parameter int              DEPTH    = 2,
  parameter logic [AW-1:0]   RESET_PC = '0
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic [AW-1:0]            imemaddr,
  output logic                     imemreq,
  input  logic [IW-1:0]            imemrdata,
  input  logic                     imemack,
  input  logic                     redirect,
  input  logic [AW-1:0]            redirectaddr,
  output logic                     idvalid,
  output logic [IW-1:0]            idinstr,
  output logic [AW-1:0]            idpcplus,
  input  logic                     idready,
  output logic [$clog2(DEPTH):0]   bufcount
);

  localparam int              PW   = $clog2(DEPTH);
  localparam int              CW   = PW + 1;
  localparam logic [CW-1:0]   FULL = CW'(DEPTH);
  localparam logic [AW-1:0]   STEP = AW'(INC);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DROP} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   pc, pc_nxt, pcplus;
  logic [AW-1:0]   dropaddr;
  logic [CW-1:0]   count, count_nxt;
  logic [PW-1:0]   wptr, rptr;
  logic            push, pop;

  logic [IW-1:0]   instr_q [DEPTH];
  logic [AW-1:0]   pcp_q   [DEPTH];

  assign pcplus = pc + STEP;  // wraps modulo 2^AW

  // Redirect wins over everything: an ack in a redirect cycle carries a
  // wrong-path instruction, and the head being popped is wrong-path too.
  assign push = (state == FETCH) && imemack && !redirect;
  assign pop  = idvalid && idready && !redirect;

  always_comb begin
    count_nxt = count;
    if (redirect) begin
      count_nxt = '0;
    end else begin
      count_nxt = count + CW'(push) - CW'(pop);
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    case (state)
      IDLE:  state_nxt = FETCH;
      FETCH: begin
        if (redirect) begin
          // Without an ack the old request is still in flight and must be drained.
          state_nxt = imemack ? FETCH : DROP;
        end else if (push && (count_nxt == FULL)) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (redirect || (count_nxt != FULL)) begin
          state_nxt = FETCH;
        end
      end
      DROP: begin
        // The ack retires the stale request; its data is never pushed. A
        // further redirect only moves the PC and the drain continues.
        if (imemack) begin
          state_nxt = FETCH;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (redirect) begin
      pc_nxt = redirectaddr;
    end else if (push) begin
      pc_nxt = pcplus;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      dropaddr <= RESET_PC;
      count    <= '0;
      wptr     <= '0;
      rptr     <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      count <= count_nxt;
      // DROP keeps presenting the address of the abandoned request so the
      // memory sees a stable request until it acknowledges.
      if ((state == FETCH) && redirect && !imemack) begin
        dropaddr <= pc;
      end
      if (redirect) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (push) begin
          wptr <= wptr + PW'(1);
        end
        if (pop) begin
          rptr <= rptr + PW'(1);
        end
      end
    end
  end

  // Storage needs no reset: entries are only visible once count covers them.
  always_ff @(posedge clock) begin
    if (push) begin
      instr_q[wptr] <= imemrdata;
      pcp_q[wptr]   <= pcplus;
    end
  end

  assign imemreq  = (state == FETCH) || (state == DROP);
  assign imemaddr = (state == DROP) ? dropaddr : pc;
  assign idvalid  = (count != '0);
  assign idinstr  = idvalid ? instr_q[rptr] : '0;
  assign idpcplus = idvalid ? pcp_q[rptr] : '0;
  assign bufcount = count;

endmodule

// File: tb/tb_pmipsl_fetch_unit.sv
// Bench for pmipsl_fetch_unit: directed scenarios with a scoreboard of expected decode outputs.
// Memory model returns {1'b1, address} after a programmable wait; a second instance checks PC wrap.
// Monitors pop and compare whenever decode accepts an instruction.
module tb_pmipsl_fetch_unit;

  logic         clock = 1'b0;
  logic         reset;
  logic [15:0]  imemaddr, redirectaddr, idpcplus;
  logic         imemreq, imemack, redirect, idvalid, idready;
  logic [16:0]  imemrdata, idinstr;
  logic [1:0]   bufcount;

  logic [15:0]  imemaddr2, idpcplus2;
  logic         imemreq2, imemack2, idvalid2, idready2;
  logic [16:0]  imemrdata2, idinstr2;
  logic [1:0]   bufcount2;

  always #5 clock = ~clock;

  pmipsl_fetch_unit dut (
    .clock(clock), .reset(reset), .imemaddr(imemaddr), .imemreq(imemreq),
    .imemrdata(imemrdata), .imemack(imemack), .redirect(redirect),
    .redirectaddr(redirectaddr), .idvalid(idvalid), .idinstr(idinstr),
    .idpcplus(idpcplus), .idready(idready), .bufcount(bufcount)
  );

  pmipsl_fetch_unit #(.RESET_PC(16'hFFFC)) dut_w (
    .clock(clock), .reset(reset), .imemaddr(imemaddr2), .imemreq(imemreq2),
    .imemrdata(imemrdata2), .imemack(imemack2), .redirect(1'b0),
    .redirectaddr(16'h0000), .idvalid(idvalid2), .idinstr(idinstr2),
    .idpcplus(idpcplus2), .idready(idready2), .bufcount(bufcount2)
  );

  // Memory for main DUT: ack once the request has been held for lat cycles.
  int   lat = 0;
  int   waitcnt;
  logic force_ack = 1'b0;
  always @(posedge clock or posedge reset) begin
    if (reset) waitcnt <= 0;
    else if (!imemreq || imemack) waitcnt <= 0;
    else waitcnt <= waitcnt + 1;
  end
  assign imemack    = force_ack | (imemreq && (waitcnt >= lat));
  assign imemrdata  = {1'b1, imemaddr};
  assign imemack2   = imemreq2;
  assign imemrdata2 = {1'b1, imemaddr2};

  typedef struct packed {
    logic [16:0] instr;
    logic [15:0] pcplus;
  } exp_t;

  exp_t exp_q[$];
  exp_t exp2_q[$];
  exp_t mon_e, mon2_e;
  int   nchecks = 0;
  int   nfail   = 0;
  int   popcnt  = 0;
  int   popcnt2 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nchecks++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic expect_pc(input int which, input logic [15:0] pc);
    exp_t e;
    e.instr  = {1'b1, pc};
    e.pcplus = pc + 16'd2;
    if (which == 0) exp_q.push_back(e);
    else exp2_q.push_back(e);
  endtask

  always @(negedge clock) begin
    if (!reset && idvalid && idready && !redirect) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_pcplus", 32'(idpcplus), 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_instr", 32'(idinstr), 32'(mon_e.instr));
        check("sb_pcplus", 32'(idpcplus), 32'(mon_e.pcplus));
      end
      popcnt++;
    end
  end

  always @(negedge clock) begin
    if (!reset && idvalid2 && idready2) begin
      if (exp2_q.size() == 0) begin
        check("sb2_unexpected_pcplus", 32'(idpcplus2), 32'hFFFF_FFFF);
      end else begin
        mon2_e = exp2_q.pop_front();
        check("sb2_instr", 32'(idinstr2), 32'(mon2_e.instr));
        check("sb2_pcplus", 32'(idpcplus2), 32'(mon2_e.pcplus));
      end
      popcnt2++;
    end
  end

  // Hold idready until n more instructions have been accepted.
  task automatic consume(input int which, input int n);
    int target;
    int budget;
    @(posedge clock); #1;
    if (which == 0) begin target = popcnt + n;  idready  = 1'b1; end
    else            begin target = popcnt2 + n; idready2 = 1'b1; end
    budget = 0;
    while (((which == 0) ? popcnt : popcnt2) < target && budget < 50) begin
      @(posedge clock); #1;
      budget++;
    end
    idready  = 1'b0;
    idready2 = 1'b0;
    check("consume_done", 32'((which == 0) ? popcnt : popcnt2), 32'(target));
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1; redirect = 1'b0; redirectaddr = '0;
    idready = 1'b0; idready2 = 1'b0; force_ack = 1'b0;
    exp_q.delete(); exp2_q.delete();
    @(negedge clock);
    check("rst_imemreq", 32'(imemreq), 0);
    check("rst_idvalid", 32'(idvalid), 0);
    check("rst_bufcount", 32'(bufcount), 0);
    check("rst_imemaddr", 32'(imemaddr), 0);
    check("rst_idinstr", 32'(idinstr), 0);
    check("rst_idpcplus", 32'(idpcplus), 0);
    check("rst_imemaddr_w", 32'(imemaddr2), 32'hFFFC);
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic end_test();
    check("sb_drained", 32'(exp_q.size()), 0);
    check("sb2_drained", 32'(exp2_q.size()), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] wrap_addr [3];
    int iters;
    int target;
    reset = 1'b1; redirect = 1'b0; redirectaddr = '0;
    idready = 1'b0; idready2 = 1'b0;

    // Zero-wait stream: one instruction per cycle, buffer never above 1.
    lat = 0;
    do_reset();
    for (int k = 0; k < 8; k++) expect_pc(0, 16'(2 * k));
    idready = 1'b1;
    target = popcnt + 8;
    @(negedge clock);
    check("zw_idle_req", 32'(imemreq), 0);
    @(negedge clock);
    check("zw_first_req", 32'(imemreq), 1);
    check("zw_first_addr", 32'(imemaddr), 0);
    check("zw_not_valid_yet", 32'(idvalid), 0);
    @(negedge clock);
    check("zw_first_valid", 32'(idvalid), 1);
    iters = 0;
    while (popcnt < target && iters < 20) begin
      @(posedge clock); #1;
      iters++;
      check("zw_bufcount_le1", 32'(bufcount <= 2'd1), 1);
    end
    idready = 1'b0;
    check("zw_cycles_for_8", 32'(iters), 8);
    end_test();

    // Stall fill: two pushes then HOLD; one pop reopens fetch at 4.
    lat = 0;
    do_reset();
    expect_pc(0, 16'h0000); expect_pc(0, 16'h0002); expect_pc(0, 16'h0004);
    repeat (5) @(negedge clock);
    check("sf_hold_req", 32'(imemreq), 0);
    check("sf_full", 32'(bufcount), 2);
    check("sf_addr", 32'(imemaddr), 16'h0004);
    check("sf_head", 32'(idpcplus), 16'h0002);
    consume(0, 1);
    @(negedge clock);
    check("sf_resume_req", 32'(imemreq), 1);
    check("sf_resume_addr", 32'(imemaddr), 16'h0004);
    check("sf_count_after_pop", 32'(bufcount), 1);
    check("sf_next_head", 32'(idpcplus), 16'h0004);
    @(negedge clock);
    check("sf_refull", 32'(bufcount), 2);
    check("sf_refull_addr", 32'(imemaddr), 16'h0006);
    consume(0, 2);
    end_test();

    // Redirect while a 3-cycle request is in flight.
    lat = 2;
    do_reset();
    expect_pc(0, 16'h0040);
    redirect = 1'b1; redirectaddr = 16'h0006;
    @(posedge clock); #1;
    redirect = 1'b0;
    repeat (3) begin @(posedge clock); #1; end
    @(negedge clock);
    check("rd_one_buffered", 32'(bufcount), 1);
    check("rd_req_addr", 32'(imemaddr), 16'h0008);
    @(posedge clock); #1;
    redirect = 1'b1; redirectaddr = 16'h0040;
    @(posedge clock); #1;
    redirect = 1'b0;
    @(negedge clock);
    check("rd_flushed", 32'(bufcount), 0);
    check("rd_not_valid", 32'(idvalid), 0);
    check("rd_drop_addr", 32'(imemaddr), 16'h0008);
    check("rd_drop_req", 32'(imemreq), 1);
    @(negedge clock);
    check("rd_new_addr", 32'(imemaddr), 16'h0040);
    check("rd_drop_no_push", 32'(bufcount), 0);
    consume(0, 1);
    end_test();

    // Redirect coincident with ack and pop.
    lat = 0;
    do_reset();
    expect_pc(0, 16'h0100);
    @(posedge clock); #1;
    @(posedge clock); #1;
    redirect = 1'b1; redirectaddr = 16'h0100; idready = 1'b1;
    @(negedge clock);
    check("rc_count_before", 32'(bufcount), 1);
    check("rc_ack_same_cycle", 32'(imemack), 1);
    @(posedge clock); #1;
    redirect = 1'b0; idready = 1'b0;
    @(negedge clock);
    check("rc_flushed", 32'(bufcount), 0);
    check("rc_not_valid", 32'(idvalid), 0);
    check("rc_addr", 32'(imemaddr), 16'h0100);
    check("rc_req", 32'(imemreq), 1);
    consume(0, 1);
    end_test();

    // PC wrap on the RESET_PC=0xFFFC instance.
    do_reset();
    wrap_addr[0] = 16'hFFFC; wrap_addr[1] = 16'hFFFE; wrap_addr[2] = 16'h0000;
    for (int k = 0; k < 3; k++) expect_pc(1, wrap_addr[k]);
    idready2 = 1'b1;
    target = popcnt2 + 3;
    @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("wr_fetch_addr", 32'(imemaddr2), 32'(wrap_addr[k]));
    end
    iters = 0;
    while (popcnt2 < target && iters < 20) begin
      @(posedge clock); #1;
      iters++;
    end
    idready2 = 1'b0;
    check("wr_pops", 32'(popcnt2), 32'(target));
    end_test();

    // Asynchronous reset in the middle of DROP, then a stray ack in IDLE.
    lat = 2;
    do_reset();
    redirect = 1'b1; redirectaddr = 16'h0010;
    @(posedge clock); #1;
    redirectaddr = 16'h0020;
    @(posedge clock); #1;
    redirect = 1'b0;
    @(negedge clock);
    check("ar_drop_addr", 32'(imemaddr), 16'h0010);
    check("ar_drop_req", 32'(imemreq), 1);
    #2 reset = 1'b1;
    #1;
    check("ar_req_now", 32'(imemreq), 0);
    check("ar_valid_now", 32'(idvalid), 0);
    check("ar_count_now", 32'(bufcount), 0);
    check("ar_addr_now", 32'(imemaddr), 0);
    do_reset();
    force_ack = 1'b1;
    @(posedge clock); #1;
    force_ack = 1'b0;
    @(negedge clock);
    check("ar_stray_ack_count", 32'(bufcount), 0);
    check("ar_first_req", 32'(imemreq), 1);
    check("ar_first_addr", 32'(imemaddr), 0);
    expect_pc(0, 16'h0000);
    consume(0, 1);
    end_test();

    $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
    $finish;
  end

endmodule

// File: doc/pmipsl_fetch_unit.md
Name: pmipsl_fetch_unit

Overview:
Parametrised instruction-fetch front end for the next-generation pipelined MIPS-Lite core. It replaces the fixed PC register and IF/ID latch with a PC sequencer, a request/acknowledge instruction-memory port tolerating variable latency, and a DEPTH-entry instruction buffer. It sits between instruction memory and the decode stage, provides decode back-pressure (stall), and supports branch/jump redirect with flush. Downstream it feeds the ID stage (register file, control).

Parameters:
AW, 16, PC / instruction-address width in bits
IW, 17, instruction width in bits
INC, 2, PC increment per instruction (byte addressing, 2-byte slots)
DEPTH, 2, instruction-buffer entries; power of 2, >= 2
RESET_PC, 0, PC value loaded on reset

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
imemaddr  out  AW  instruction-memory address (current PC while requesting)
imemreq  out  1  fetch request
imemrdata  in  IW  instruction data, valid when imemack=1
imemack  in  1  memory acknowledge; completes the outstanding request
redirect  in  1  branch/jump taken: flush and reload PC (from MEM stage)
redirectaddr  in  AW  new PC on redirect
idvalid  out  1  buffer head holds a valid instruction
idinstr  out  IW  buffer-head instruction
idpcplus  out  AW  PC+INC of the head instruction
idready  in  1  decode accepts head this cycle (0 = stall)
bufcount  out  log2(DEPTH)+1  occupied entries

Behaviour:
- Reset (async, immediate): PC=RESET_PC, state IDLE, count=0, pointers=0. Outputs: imemreq=0, idvalid=0, bufcount=0, imemaddr=RESET_PC; idinstr/idpcplus=0.
- States: IDLE, FETCH, HOLD, DROP. imemreq=1 in FETCH and DROP only.
- IDLE: next cycle -> FETCH (first request one cycle after reset release).
- Memory protocol: imemreq and imemaddr are held stable until imemack. One request outstanding at most. Ack is sampled only when imemreq=1; an ack in the same cycle as req is legal (0-wait memory).
- FETCH, ack, no redirect: push {imemrdata, PC+INC}, PC<=PC+INC. If the post-push/post-pop count is DEPTH -> HOLD, else stay FETCH.
- HOLD: no request. -> FETCH when count<DEPTH (after a pop). A pop in HOLD moves to FETCH next cycle (one bubble).
- Pop: on idvalid&idready. Head advances; push and pop in the same cycle leave count unchanged.
- Redirect (priority over push/pop): count<=0, pointers<=0, PC<=redirectaddr; the pop is ignored.
  - FETCH with no ack that cycle: request in flight -> DROP.
  - FETCH with ack same cycle: data discarded -> FETCH.
  - HOLD or IDLE: -> FETCH.
  - DROP: PC updated, stay DROP.
- DROP: imemaddr holds the old address, req=1. On ack, data discarded, no push, PC unchanged -> FETCH with the redirected PC.
- Arithmetic: PC+INC modulo 2^AW (wrap to 0, no flag). Buffer pointers wrap modulo DEPTH.
- idvalid = (count!=0). idinstr/idpcplus driven combinationally from the head entry, stable while idready=0.
- Ordering: instructions leave in fetch order. No instruction fetched before a redirect is ever presented after it.
- Reset mid-request: the outstanding request is abandoned. A late ack after reset release, while in IDLE, is ignored.

Test Plan:
- Zero-wait stream: reset release, imemack=imemreq each cycle, idready=1, mem returns addr-tagged data -> idpcplus 2,4,6,...; first idvalid 2 cycles after reset release; one instruction per cycle; bufcount stays <=1.
- Stall fill (DEPTH=2): idready=0 from start -> two pushes (PC 0,2), state HOLD, imemreq=0, bufcount=2, imemaddr=4. Raise idready for 1 cycle -> pop of instr@0, FETCH resumes at 4, order preserved.
- Redirect with request in flight: 3-cycle memory, assert redirect addr=0x0040 one cycle after req@0x0008 -> buffer flushed, imemaddr stays 0x0008 until ack, ack data dropped, next req at 0x0040, first idpcplus=0x0042.
- Redirect coincident with ack and pop: count=1, ack and idready=1 in the redirect cycle -> bufcount=0 next cycle, no stale instr, imemaddr=redirectaddr.
- PC wrap: RESET_PC=0xFFFC, AW=16 -> fetch addresses 0xFFFC, 0xFFFE, 0x0000; idpcplus 0xFFFE, 0x0000, 0x0002.
- Async reset mid-DROP: reset asserted between clock edges -> imemreq=0, idvalid=0, bufcount=0 immediately; after release, first request at RESET_PC; a stray ack while in IDLE leaves bufcount at 0.
